// File: rtl/alu_sequencer.sv
// alu_sequencer
// Instruction sequencer and accumulator controller for a shared 8-bit ALU.
// Incoming instructions are buffered in a small FIFO and issued one at a time.
// After each issue the sequencer waits out the ALU latency. The ALU result is
// then written back into the accumulator and offered on a valid/ready port.
//
// Parameters:
//   DEPTH        instruction FIFO entries (power of 2, >= 2)
//   ALU_LATENCY  clock edges from ALU input sampling to ALU_Out valid (>= 1)
//
// Ports:
//   clk, rst_n                        clock (rising edge), async active-low reset
//   in_valid/in_ready                 instruction push handshake
//   in_use_acc, in_opcode, in_a, in_b instruction fields
//   clr_acc                           synchronous accumulator clear
//   alu_a, alu_b, alu_opcode          registered operands driven to the ALU
//   alu_out                           ALU result
//   res_valid/res_ready, res_data     result handshake
//   acc                               accumulator value
//   busy                              FSM active or FIFO non-empty
//   zero                              result-zero flag (optional feature)
//
// Optional feature macro: ALU_SEQ_ZERO_FLAG_EN
//   defined   : zero is registered on writeback as (alu_out == 0). It is
//               cleared by reset and by clr_acc.
//   undefined : zero is tied low.

module alu_sequencer #(
  parameter int DEPTH       = 4,
  parameter int ALU_LATENCY = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_use_acc,
  input  logic [3:0] in_opcode,
  input  logic [7:0] in_a,
  input  logic [7:0] in_b,
  input  logic       clr_acc,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [3:0] alu_opcode,
  input  logic [7:0] alu_out,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_data,
  output logic [7:0] acc,
  output logic       busy,
  output logic       zero
);

  localparam int AW      = $clog2(DEPTH);
  localparam int PW      = AW + 1;
  localparam int CW      = (ALU_LATENCY < 1) ? 1 : $clog2(ALU_LATENCY + 1);
  localparam int ENTRY_W = 21;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [ENTRY_W-1:0]  fifo_mem [DEPTH];
  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       rd_ptr;
  logic                full;
  logic                empty;
  logic                push;
  logic                pop;
  logic                writeback;
  logic                release_res;
  logic [CW-1:0]       cnt;
  logic [ENTRY_W-1:0]  head;
  logic                head_use_acc;
  logic [3:0]          head_opcode;
  logic [7:0]          head_a;
  logic [7:0]          head_b;

  // Pointers carry one extra wrap bit: equal low bits with differing MSBs
  // means full, fully equal means empty.
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty    = (wr_ptr == rd_ptr);
  assign in_ready = !full;
  assign push     = in_valid && !full;
  assign busy     = (state != IDLE) || !empty;

  assign head = fifo_mem[rd_ptr[AW-1:0]];
  assign {head_use_acc, head_opcode, head_a, head_b} = head;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr[AW-1:0]] <= {in_use_acc, in_opcode, in_a, in_b};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    pop         = 1'b0;
    writeback   = 1'b0;
    release_res = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          writeback = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (res_ready) begin
          release_res = 1'b1;
          state_nxt   = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand A is taken from acc before any clear that happens on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= '0;
      cnt        <= '0;
    end else begin
      if (pop) begin
        alu_a      <= head_use_acc ? acc : head_a;
        alu_b      <= head_b;
        alu_opcode <= head_opcode;
        cnt        <= CW'(ALU_LATENCY);
      end else if ((state == WAIT) && (cnt != '0)) begin
        cnt <= cnt - CW'(1);
      end
    end
  end

  // When clr_acc and writeback coincide, the clear wins for acc.
  // res_data still takes the ALU result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      acc       <= '0;
    end else begin
      if (writeback) begin
        res_valid <= 1'b1;
        res_data  <= alu_out;
      end else if (release_res) begin
        res_valid <= 1'b0;
      end
      if (clr_acc) begin
        acc <= '0;
      end else if (writeback) begin
        acc <= alu_out;
      end
    end
  end

`ifdef ALU_SEQ_ZERO_FLAG_EN
  logic zero_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_q <= 1'b0;
    end else if (clr_acc) begin
      zero_q <= 1'b0;
    end else if (writeback) begin
      zero_q <= (alu_out == 8'h00);
    end
  end

  assign zero = zero_q;
`else
  assign zero = 1'b0;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Testbench for alu_sequencer.
// An 8-bit ALU stand-in with a configurable pipeline depth feeds the DUT.
// A transaction-level reference model keeps a queue of pending instructions
// plus the issue/writeback timing. A compare process checks every DUT output
// against this model on each falling edge. Directed scenarios add hand-computed
// literal expectations, which pin the model itself.

module tb_alu_sequencer;

  localparam int DEPTH   = 4;
  localparam int ALU_LAT = 1;

  logic       clk        = 1'b0;
  logic       rst_n      = 1'b0;
  logic       in_valid   = 1'b0;
  logic       in_use_acc = 1'b0;
  logic [3:0] in_opcode  = 4'h0;
  logic [7:0] in_a       = 8'h00;
  logic [7:0] in_b       = 8'h00;
  logic       clr_acc    = 1'b0;
  logic       res_ready  = 1'b1;
  logic       in_ready;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [3:0] alu_opcode;
  logic [7:0] alu_out;
  logic       res_valid;
  logic [7:0] res_data;
  logic [7:0] acc;
  logic       busy;
  logic       zero;

  int nChecks = 0;
  int nErrors = 0;

  always #5 clk = ~clk;

  alu_sequencer #(
    .DEPTH      (DEPTH),
    .ALU_LATENCY(ALU_LAT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_use_acc(in_use_acc),
    .in_opcode (in_opcode),
    .in_a      (in_a),
    .in_b      (in_b),
    .clr_acc   (clr_acc),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_opcode(alu_opcode),
    .alu_out   (alu_out),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .acc       (acc),
    .busy      (busy),
    .zero      (zero)
  );

  // ALU behaviour used by both the stand-in and the reference model
  function automatic logic [7:0] aluFn(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      4'h0:    return a + b;
      4'h1:    return a - b;
      4'h2:    return a & b;
      4'h3:    return a | b;
      4'h4:    return a ^ b;
      default: return a;
    endcase
  endfunction

  // ALU stand-in: samples inputs on every edge, result valid ALU_LAT edges later
  logic [7:0] aluPipe [ALU_LAT];

  always @(posedge clk) begin
    aluPipe[0] <= aluFn(alu_opcode, alu_a, alu_b);
    for (int i = 1; i < ALU_LAT; i++) aluPipe[i] <= aluPipe[i-1];
  end

  assign alu_out = aluPipe[ALU_LAT-1];

  // Reference model: queue of instructions plus issue/writeback timing
  typedef struct packed {
    logic       useAcc;
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
  } instr_t;

  instr_t     modelQ[$];
  instr_t     mInstr;
  int         edgeN    = 0;
  int         wbEdge   = 0;
  bit         inFlight = 1'b0;
  bit         holding  = 1'b0;
  bit         canPush;
  logic [7:0] mAluA    = 8'h00;
  logic [7:0] mAluB    = 8'h00;
  logic [3:0] mOp      = 4'h0;
  logic [7:0] mRes     = 8'h00;
  logic [7:0] mAcc     = 8'h00;
  logic [7:0] result;
  logic       mValid   = 1'b0;
  logic       mZero    = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      modelQ.delete();
      inFlight = 1'b0;
      holding  = 1'b0;
      mAluA    = 8'h00;
      mAluB    = 8'h00;
      mOp      = 4'h0;
      mRes     = 8'h00;
      mAcc     = 8'h00;
      mValid   = 1'b0;
      mZero    = 1'b0;
      edgeN    = 0;
    end else begin
      canPush = (modelQ.size() < DEPTH);
      if (!inFlight && !holding && modelQ.size() > 0) begin
        mInstr   = modelQ.pop_front();
        mAluA    = mInstr.useAcc ? mAcc : mInstr.a;
        mAluB    = mInstr.b;
        mOp      = mInstr.op;
        inFlight = 1'b1;
        wbEdge   = edgeN + ALU_LAT + 1;
      end else if (inFlight && edgeN == wbEdge) begin
        result   = aluFn(mOp, mAluA, mAluB);
        mRes     = result;
        mAcc     = result;
        mValid   = 1'b1;
        mZero    = (result == 8'h00);
        inFlight = 1'b0;
        holding  = 1'b1;
      end else if (holding && res_ready) begin
        mValid  = 1'b0;
        holding = 1'b0;
      end
      if (clr_acc) begin
        mAcc  = 8'h00;
        mZero = 1'b0;
      end
      if (in_valid && canPush) begin
        mInstr = {in_use_acc, in_opcode, in_a, in_b};
        modelQ.push_back(mInstr);
      end
      edgeN++;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nErrors++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
    end
  endtask

  task automatic failTimeout(input string name);
    nChecks++;
    nErrors++;
    $display("[TB] FAIL %s at %0t: wait bound expired", name, $time);
  endtask

  // Compare process: every output is meaningful on every cycle
  always @(negedge clk) begin
    checkOutput("cmp_in_ready", in_ready, modelQ.size() < DEPTH);
    checkOutput("cmp_busy", busy, inFlight || holding || (modelQ.size() != 0));
    checkOutput("cmp_res_valid", res_valid, mValid);
    checkOutput("cmp_res_data", res_data, mRes);
    checkOutput("cmp_acc", acc, mAcc);
    checkOutput("cmp_alu_a", alu_a, mAluA);
    checkOutput("cmp_alu_b", alu_b, mAluB);
    checkOutput("cmp_alu_opcode", alu_opcode, mOp);
`ifdef ALU_SEQ_ZERO_FLAG_EN
    checkOutput("cmp_zero", zero, mZero);
`else
    checkOutput("cmp_zero", zero, 1'b0);
`endif
  end

  // Drives one instruction from a falling edge and holds it until accepted
  task automatic applyStimulus(input logic ua, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    int waitCycles = 0;
    @(negedge clk);
    in_valid   = 1'b1;
    in_use_acc = ua;
    in_opcode  = op;
    in_a       = a;
    in_b       = b;
    while (!in_ready && waitCycles < 200) begin
      @(negedge clk);
      waitCycles++;
    end
    if (!in_ready) failTimeout("push_accept");
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic waitIdle();
    int waitCycles = 0;
    @(negedge clk);
    while ((busy || res_valid) && waitCycles < 300) begin
      @(negedge clk);
      waitCycles++;
    end
    if (busy || res_valid) failTimeout("wait_idle");
  endtask

  task automatic waitResult();
    int waitCycles = 0;
    while (!res_valid && waitCycles < 300) begin
      @(negedge clk);
      waitCycles++;
    end
    if (!res_valid) failTimeout("wait_result");
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog at %0t: simulation did not complete", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  logic [7:0] drainExp [5];
  instr_t     fillVec  [5];
  int         sawValid;

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("reset_in_ready", in_ready, 1'b1);
    checkOutput("reset_res_valid", res_valid, 1'b0);
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_acc", acc, 8'h00);
    checkOutput("reset_alu_a", alu_a, 8'h00);
    checkOutput("reset_zero", zero, 1'b0);
    #2 rst_n = 1'b1;

    // Single ADD 1+1: res_valid rises three edges after acceptance
    $display("[TB] single ADD latency");
    res_ready = 1'b1;
    applyStimulus(1'b0, 4'h0, 8'h01, 8'h01);
    repeat (3) @(negedge clk);
    checkOutput("t1_valid_early", res_valid, 1'b0);
    @(negedge clk);
    checkOutput("t1_valid", res_valid, 1'b1);
    checkOutput("t1_res_data", res_data, 8'h02);
    checkOutput("t1_acc", acc, 8'h02);
    checkOutput("t1_alu_a", alu_a, 8'h01);
    waitIdle();

    // Chain through the accumulator
    $display("[TB] accumulator chain");
    applyStimulus(1'b0, 4'h0, 8'h01, 8'h01);
    applyStimulus(1'b1, 4'h0, 8'h00, 8'h05);
    waitIdle();
    checkOutput("t2_res_data", res_data, 8'h07);
    checkOutput("t2_acc", acc, 8'h07);
    checkOutput("t2_alu_a", alu_a, 8'h02);
    checkOutput("t2_alu_b", alu_b, 8'h05);

    // Back-pressure: fill FIFO plus one in flight, then drain in order
    $display("[TB] back-pressure and drain");
    res_ready   = 1'b0;
    fillVec[0]  = {1'b0, 4'h0, 8'h01, 8'h02};
    fillVec[1]  = {1'b0, 4'h1, 8'h10, 8'h01};
    fillVec[2]  = {1'b0, 4'h2, 8'hF0, 8'h3C};
    fillVec[3]  = {1'b0, 4'h4, 8'hFF, 8'h0F};
    fillVec[4]  = {1'b1, 4'h0, 8'h00, 8'h10};
    drainExp[0] = 8'h03;
    drainExp[1] = 8'h0F;
    drainExp[2] = 8'h30;
    drainExp[3] = 8'hF0;
    drainExp[4] = 8'h00;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(fillVec[i].useAcc, fillVec[i].op, fillVec[i].a, fillVec[i].b);
    end
    @(negedge clk);
    checkOutput("t3_in_ready_full", in_ready, 1'b0);
    checkOutput("t3_held_valid", res_valid, 1'b1);
    checkOutput("t3_held_data", res_data, 8'h03);
    repeat (4) @(negedge clk);
    checkOutput("t3_still_valid", res_valid, 1'b1);
    checkOutput("t3_still_data", res_data, 8'h03);
    checkOutput("t3_still_full", in_ready, 1'b0);
    res_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      waitResult();
      checkOutput($sformatf("t3_drain_%0d", i), res_data, drainExp[i]);
      @(posedge clk);
      @(negedge clk);
    end
    waitIdle();
    checkOutput("t3_acc", acc, 8'h00);

    // clr_acc on the writeback edge of ADD 3+4
    $display("[TB] clear on writeback");
    applyStimulus(1'b0, 4'h0, 8'h03, 8'h04);
    repeat (3) @(negedge clk);
    clr_acc = 1'b1;
    @(negedge clk);
    clr_acc = 1'b0;
    checkOutput("t4_res_valid", res_valid, 1'b1);
    checkOutput("t4_res_data", res_data, 8'h07);
    checkOutput("t4_acc_cleared", acc, 8'h00);
    waitIdle();
    applyStimulus(1'b1, 4'h0, 8'hAA, 8'h09);
    waitIdle();
    checkOutput("t4_alu_a", alu_a, 8'h00);
    checkOutput("t4_res_data2", res_data, 8'h09);
    checkOutput("t4_acc2", acc, 8'h09);

    // Reset during WAIT with two instructions queued
    $display("[TB] reset mid-operation");
    applyStimulus(1'b0, 4'h0, 8'h01, 8'h01);
    applyStimulus(1'b0, 4'h0, 8'h02, 8'h02);
    applyStimulus(1'b0, 4'h0, 8'h03, 8'h03);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t5_res_valid", res_valid, 1'b0);
    checkOutput("t5_busy", busy, 1'b0);
    checkOutput("t5_in_ready", in_ready, 1'b1);
    checkOutput("t5_acc", acc, 8'h00);
    checkOutput("t5_alu_a", alu_a, 8'h00);
    checkOutput("t5_alu_b", alu_b, 8'h00);
    checkOutput("t5_alu_opcode", alu_opcode, 4'h0);
    checkOutput("t5_res_data", res_data, 8'h00);
    @(negedge clk);
    #2 rst_n = 1'b1;
    sawValid = 0;
    repeat (8) begin
      @(negedge clk);
      if (res_valid) sawValid++;
    end
    checkOutput("t5_no_result", sawValid, 0);
    checkOutput("t5_fifo_empty", busy, 1'b0);

    // Zero flag
    $display("[TB] zero flag");
    applyStimulus(1'b0, 4'h0, 8'hFF, 8'h01);
    waitIdle();
    checkOutput("t6_res_data", res_data, 8'h00);
`ifdef ALU_SEQ_ZERO_FLAG_EN
    checkOutput("t6_zero_set", zero, 1'b1);
`else
    checkOutput("t6_zero_tied", zero, 1'b0);
`endif
    applyStimulus(1'b0, 4'h0, 8'h01, 8'h01);
    waitIdle();
    checkOutput("t6_res_data2", res_data, 8'h02);
    checkOutput("t6_zero_clear", zero, 1'b0);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
